// File: rtl/sha256_msg_ctrl.sv
// Multi-block SHA-256 sequencer: picks H0 or chaining value, starts the core, chains and emits the digest.
// Latency: block accept to digest sample is 2 + core rounds + SAMPLE_DLY cycles; RUN aborts after TIMEOUT_CYC.
// Backpressure: blk_ready only in IDLE; digest held in OUT until dig_ready. Option: SHA256_MSG_CTRL_BLKCNT_EN.
module sha256_msg_ctrl #(
  parameter int TIMEOUT_CYC = 80,
  parameter int SAMPLE_DLY  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] dig_data,
  output logic [255:0] core_h,
  output logic [511:0] core_m,
  output logic         core_start,
  input  logic         core_done,
  input  logic [255:0] core_digest,
  output logic         busy,
  output logic         err_timeout
`ifdef SHA256_MSG_CTRL_BLKCNT_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  typedef enum logic [2:0] {IDLE, LOAD, RUN, SETTLE, OUT} state_t;

  state_t             state_q, state_d;
  logic [255:0]       core_h_q, core_h_d;
  logic [511:0]       core_m_q, core_m_d;
  logic               last_q, last_d;
  logic [255:0]       chain_q, chain_d;
  logic               chain_act_q, chain_act_d;
  logic [255:0]       dig_q, dig_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [1:0]         settle_q, settle_d;
  logic               blk_acc;

  assign blk_acc = blk_valid && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      core_h_q    <= '0;
      core_m_q    <= '0;
      last_q      <= 1'b0;
      chain_q     <= '0;
      chain_act_q <= 1'b0;
      dig_q       <= '0;
      err_q       <= 1'b0;
      run_cnt_q   <= '0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      core_h_q    <= core_h_d;
      core_m_q    <= core_m_d;
      last_q      <= last_d;
      chain_q     <= chain_d;
      chain_act_q <= chain_act_d;
      dig_q       <= dig_d;
      err_q       <= err_d;
      run_cnt_q   <= run_cnt_d;
      settle_q    <= settle_d;
    end
  end

  // core_h/core_m only change on block accept, so they stay put from LOAD through SETTLE.
  always_comb begin
    state_d     = state_q;
    core_h_d    = core_h_q;
    core_m_d    = core_m_q;
    last_d      = last_q;
    chain_d     = chain_q;
    chain_act_d = chain_act_q;
    dig_d       = dig_q;
    err_d       = err_q;
    run_cnt_d   = run_cnt_q;
    settle_d    = settle_q;
    case (state_q)
      IDLE: begin
        if (blk_acc) begin
          core_m_d = blk_data;
          last_d   = blk_last;
          core_h_d = (blk_first || !chain_act_q) ? H0 : chain_q;
          if (blk_first) err_d = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        run_cnt_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        if (core_done) begin
          settle_d = 2'(SAMPLE_DLY);
          state_d  = SETTLE;
        end else if (run_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d       = 1'b1;
          chain_act_d = 1'b0;
          state_d     = IDLE;
        end
      end
      SETTLE: begin
        if (settle_q == 2'd0) begin
          chain_d = core_digest;
          if (last_q) begin
            dig_d       = core_digest;
            chain_act_d = 1'b0;
            state_d     = OUT;
          end else begin
            chain_act_d = 1'b1;
            state_d     = IDLE;
          end
        end else begin
          settle_d = settle_q - 2'd1;
        end
      end
      OUT: begin
        if (dig_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign blk_ready   = (state_q == IDLE);
  assign core_start  = (state_q == LOAD);
  assign dig_valid   = (state_q == OUT);
  assign busy        = (state_q != IDLE);
  assign dig_data    = dig_q;
  assign core_h      = core_h_q;
  assign core_m      = core_m_q;
  assign err_timeout = err_q;

`ifdef SHA256_MSG_CTRL_BLKCNT_EN
  logic [15:0] blk_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_q <= '0;
    end else if (blk_acc && !dig_valid) begin
      if (blk_first)                blk_cnt_q <= 16'd1;
      else if (blk_cnt_q != 16'hffff) blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Scoreboard bench for sha256_msg_ctrl with a behavioural SHA-256 core stub.
module tb_sha256_msg_ctrl;

  localparam int TIMEOUT_CYC = 80;
  localparam int SAMPLE_DLY  = 1;
  localparam int ROUNDS      = 64;

  localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] TWO_B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk, rst_n;
  logic         blk_valid, blk_ready, blk_first, blk_last;
  logic [511:0] blk_data;
  logic         dig_valid, dig_ready;
  logic [255:0] dig_data, core_h, core_digest;
  logic [511:0] core_m;
  logic         core_start, core_done, busy, err_timeout;
`ifdef SHA256_MSG_CTRL_BLKCNT_EN
  logic [15:0]  blk_cnt;
`endif

  sha256_msg_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .SAMPLE_DLY(SAMPLE_DLY)) dut (
    .clk(clk), .rst_n(rst_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
    .core_h(core_h), .core_m(core_m), .core_start(core_start),
    .core_done(core_done), .core_digest(core_digest),
    .busy(busy), .err_timeout(err_timeout)
`ifdef SHA256_MSG_CTRL_BLKCNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  logic prev_start = 1'b0;
  logic [255:0] exp_h [$];
  logic [255:0] exp_dig [$];
  logic [15:0]  exp_cnt [$];

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  // Core stub: feed-forward uses the live core_h/core_m so any instability shows in the digest.
  logic hang = 1'b0;
  logic spur = 1'b0;
  logic st_act = 1'b0;
  int   st_cnt = 0;
  initial core_done = 1'b0;
  initial core_digest = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      st_act    <= 1'b0;
      core_done <= 1'b0;
    end else begin
      core_done <= spur;
      if (core_start) begin
        st_cnt <= ROUNDS;
        st_act <= 1'b1;
      end else if (st_act) begin
        if (st_cnt == 1) begin
          st_act <= 1'b0;
          if (!hang) begin
            core_done   <= 1'b1;
            core_digest <= sha_compress(core_h, core_m);
          end
        end else begin
          st_cnt <= st_cnt - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (core_start) begin
        n_start++;
        chk("start_one_cycle", prev_start, 1'b0);
        if (exp_h.size() == 0) fail("unexpected_core_start");
        else chk("core_h_at_start", core_h, exp_h.pop_front());
      end
      if (dig_valid && dig_ready) begin
        if (exp_dig.size() == 0) begin
          fail("unexpected_digest");
        end else begin
          logic [15:0] ec;
          ec = exp_cnt.pop_front();
          chk("dig_data", dig_data, exp_dig.pop_front());
`ifdef SHA256_MSG_CTRL_BLKCNT_EN
          chk("blk_cnt", blk_cnt, ec);
`endif
        end
      end
    end
    prev_start = core_start;
  end

  task automatic push_dig(input logic [255:0] d, input logic [15:0] c);
    exp_dig.push_back(d);
    exp_cnt.push_back(c);
  endtask

  task automatic send(input logic [511:0] d, input logic f, input logic l);
    int k;
    k = 0;
    while (!blk_ready && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    if (!blk_ready) fail("send_wait_ready");
    blk_valid = 1'b1; blk_data = d; blk_first = f; blk_last = l;
    @(posedge clk); #1;
    blk_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string nm);
    int k;
    k = 0;
    while ((busy || exp_dig.size() != 0) && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy || exp_dig.size() != 0) fail(nm);
  endtask

  initial begin
    int s0, k;
    logic saw_dv;
    rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0; blk_first = 1'b0; blk_last = 1'b0;
    dig_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_blk_ready", blk_ready, 1'b1);
    chk("rst_dig_valid", dig_valid, 1'b0);
    chk("rst_dig_data", dig_data, '0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_core_h", core_h, '0);
    chk("rst_core_m", core_m[255:0] | core_m[511:256], '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(posedge clk); #1;
    chk("done_in_idle_busy", busy, 1'b0);
    chk("done_in_idle_ready", blk_ready, 1'b1);

    s0 = n_start;
    exp_h.push_back(H0);
    push_dig(ABC_DIG, 16'd1);
    send(ABC_BLK, 1'b1, 1'b1);
    wait_quiet("abc_wait");
    chk("abc_start_count", n_start - s0, 1);

    exp_h.push_back(H0);
    exp_h.push_back(sha_compress(H0, TWO_B1));
    push_dig(TWO_DIG, 16'd2);
    send(TWO_B1, 1'b1, 1'b0);
    send(TWO_B2, 1'b0, 1'b1);
    wait_quiet("two_wait");

    dig_ready = 1'b0;
    exp_h.push_back(H0);
    push_dig(ABC_DIG, 16'd1);
    send(ABC_BLK, 1'b1, 1'b1);
    k = 0;
    while (!dig_valid && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    if (!dig_valid) fail("bp_wait_valid");
    repeat (10) begin
      @(negedge clk);
      chk("bp_dig_valid", dig_valid, 1'b1);
      chk("bp_dig_data", dig_data, ABC_DIG);
      chk("bp_blk_ready", blk_ready, 1'b0);
    end
    @(posedge clk); #1;
    dig_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released_valid", dig_valid, 1'b0);
    chk("bp_popped", exp_dig.size(), 0);

    hang = 1'b1;
    exp_h.push_back(H0);
    send(ABC_BLK, 1'b1, 1'b1);
    @(posedge clk); #1;
    k = 0;
    saw_dv = 1'b0;
    while (!err_timeout && k < 300) begin
      @(posedge clk); #1;
      k++;
      saw_dv = saw_dv | dig_valid;
    end
    chk("timeout_cycles", k, TIMEOUT_CYC);
    chk("timeout_err", err_timeout, 1'b1);
    chk("timeout_idle", busy, 1'b0);
    chk("timeout_no_digest", saw_dv, 1'b0);
    hang = 1'b0;

    exp_h.push_back(H0);
    push_dig(ABC_DIG, 16'd2);
    send(ABC_BLK, 1'b0, 1'b1);
    chk("err_sticky_nonfirst", err_timeout, 1'b1);
    wait_quiet("nonfirst_wait");

    exp_h.push_back(H0);
    push_dig(ABC_DIG, 16'd1);
    send(ABC_BLK, 1'b1, 1'b1);
    chk("err_cleared_first", err_timeout, 1'b0);
    wait_quiet("first_wait");

    exp_h.push_back(H0);
    exp_h.push_back(sha_compress(H0, TWO_B1));
    send(TWO_B1, 1'b1, 1'b0);
    send(TWO_B2, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_blk_ready", blk_ready, 1'b1);
    chk("mid_rst_core_h", core_h, '0);
    chk("mid_rst_core_m", core_m[255:0] | core_m[511:256], '0);
    chk("mid_rst_dig_data", dig_data, '0);
    chk("mid_rst_dig_valid", dig_valid, 1'b0);
    chk("mid_rst_err", err_timeout, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_h.push_back(H0);
    push_dig(ABC_DIG, 16'd1);
    send(ABC_BLK, 1'b0, 1'b1);
    wait_quiet("post_rst_wait");

    repeat (3) @(posedge clk);
    #1;
    chk("exp_h_drained", exp_h.size(), 0);
    chk("exp_dig_drained", exp_dig.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
